// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: picks the next PC each cycle and keeps at most one
// instruction-memory request outstanding. Returned words go to decode through
// a single-entry output buffer.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_curr,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_RESET,
    S_REQ,
    S_RSP,
    S_KILL
  } state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic        handshake;
  logic        flush;
  logic        misaligned;

  assign imem_req_addr = pc_curr;

  // Request issue, flush detection and next-PC priority selection.
  always_comb begin
    // A request only goes out when the buffer will be free for its response.
    imem_req_valid = !rst && (state == S_REQ) && (!if_valid || if_ready);
    handshake      = imem_req_valid && imem_req_ready;
    flush          = trap_valid || redirect_valid;
    misaligned     = (redirect_pc[1:0] != 2'b00);
    pc_next        = pc_curr;
    if (rst) begin
      pc_next = RESET_ADDR;
    end else if (trap_valid) begin
      pc_next = TRAP_VEC;
    end else if (redirect_valid) begin
      pc_next = misaligned ? TRAP_VEC : redirect_pc;
    end else if (handshake) begin
      pc_next = pc_curr + 32'd4;
    end
  end

  // Sequencer state, output buffer and misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      req_pc       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && !trap_valid && misaligned;

      if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end

      case (state)
        S_RESET: state <= S_REQ;
        S_REQ: begin
          if (handshake) begin
            req_pc <= pc_curr;
            state  <= flush ? S_KILL : S_RSP;
          end
        end
        S_RSP: begin
          if (imem_rsp_valid) begin
            if (!flush) begin
              if_valid <= 1'b1;
              if_instr <= imem_rsp_data;
              if_pc    <= req_pc;
            end
            state <= S_REQ;
          end else if (flush) begin
            state <= S_KILL;
          end
        end
        S_KILL: begin
          // The stale response retires the outstanding request; a flush in the
          // same cycle has nothing left to cancel, so fetching resumes.
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_RESET;
      endcase

      // Flush wins over any refill or consume on the same edge.
      if (flush) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model (outstanding request + buffer contents).
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_curr;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(
    .RESET_ADDR(RESET_ADDR),
    .TRAP_VEC  (TRAP_VEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_curr       (pc_curr),
    .pc_next       (pc_next),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // PC register fed by pc_next.
  always @(posedge clk) pc_curr <= pc_next;

  // Memory: fixed latency (in edges) sampled at request acceptance.
  int unsigned mem_lat = 1;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;
  logic        mem_rsp_v;
  logic [31:0] mem_rsp_d;
  logic        inj_rsp;

  assign imem_rsp_valid = mem_rsp_v | inj_rsp;
  assign imem_rsp_data  = inj_rsp ? 32'hDEAD_BEEF : mem_rsp_d;

  always @(posedge clk) begin
    if (rst) begin
      mem_cnt   <= 0;
      mem_rsp_v <= 1'b0;
    end else begin
      mem_rsp_v <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (mem_lat <= 1) begin
          mem_rsp_v <= 1'b1;
          mem_rsp_d <= word_at(imem_req_addr);
        end else begin
          mem_cnt  <= mem_lat - 1;
          mem_addr <= imem_req_addr;
        end
      end else if (mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
        if (mem_cnt == 1) begin
          mem_rsp_v <= 1'b1;
          mem_rsp_d <= word_at(mem_addr);
        end
      end
    end
  end

  // Reference model: whether a fetch is in flight (and doomed), and what the
  // decode buffer should hold.
  typedef struct packed {
    logic        bv;
    logic [31:0] bpc;
    logic        out;
    logic        kill;
    logic [31:0] opc;
  } mstate_t;

  mstate_t m;
  logic    m_live;
  logic    m_mis;

  function automatic logic m_issue();
    return !rst && m_live && !m.out && (!m.bv || if_ready);
  endfunction

  function automatic logic [31:0] exp_pc_next();
    if (rst) return RESET_ADDR;
    if (trap_valid) return TRAP_VEC;
    if (redirect_valid) return (redirect_pc[1:0] != 2'b00) ? TRAP_VEC : redirect_pc;
    if (m_issue() && imem_req_ready) return pc_curr + 32'd4;
    return pc_curr;
  endfunction

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t n;
    logic    fl;
    logic    hs;
    n  = s;
    fl = trap_valid || redirect_valid;
    hs = m_issue() && imem_req_ready;
    if (n.bv && if_ready) n.bv = 1'b0;
    if (n.out && imem_rsp_valid) begin
      if (!n.kill && !fl) begin
        n.bv  = 1'b1;
        n.bpc = n.opc;
      end
      n.out  = 1'b0;
      n.kill = 1'b0;
    end
    if (hs) begin
      n.out  = 1'b1;
      n.opc  = pc_curr;
      n.kill = fl;
    end else if (n.out && fl) begin
      n.kill = 1'b1;
    end
    if (fl) n.bv = 1'b0;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m      <= '0;
      m_live <= 1'b0;
      m_mis  <= 1'b0;
    end else begin
      m      <= model_step(m);
      m_live <= 1'b1;
      m_mis  <= redirect_valid && !trap_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inj_rsp        = 1'b0;
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    idle_inputs();
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    idle_inputs();
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (pc_next !== RESET_ADDR) begin failures++; $display("FAIL reset_pc_next: got %h want %h", pc_next, RESET_ADDR); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin failures++; $display("FAIL reset_buffer: if_pc %h if_instr %h want 0 0", if_pc, if_instr); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL first_cycle_no_req: got %b want 0", imem_req_valid); end
    cyc();
  endtask

  task automatic test_sequential();
    logic [31:0] req_q[$];
    logic [31:0] nxt_q[$];
    logic [31:0] out_q[$];
    logic        bad_instr = 1'b0;
    logic        mis_seen  = 1'b0;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        req_q.push_back(imem_req_addr);
        nxt_q.push_back(pc_next);
      end
      if (if_valid && if_ready) begin
        out_q.push_back(if_pc);
        if (if_instr !== word_at(if_pc)) bad_instr = 1'b1;
      end
      if (misalign_err !== 1'b0) mis_seen = 1'b1;
      cyc();
    end
    checks++;
    if (req_q.size() < 3 || out_q.size() < 3) begin
      failures++;
      $display("FAIL seq_counts: requests %0d outputs %0d want >=3 each", req_q.size(), out_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (req_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, req_q[i], 32'(4 * i)); end
        checks++; if (nxt_q[i] !== 32'(4 * i + 4)) begin failures++; $display("FAIL seq_pc_next[%0d]: got %h want %h", i, nxt_q[i], 32'(4 * i + 4)); end
        checks++; if (out_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_if_pc[%0d]: got %h want %h", i, out_q[i], 32'(4 * i)); end
      end
    end
    checks++; if (bad_instr) begin failures++; $display("FAIL seq_if_instr: instruction did not match memory word at if_pc"); end
    checks++; if (mis_seen) begin failures++; $display("FAIL seq_misalign: got 1 want 0"); end
  endtask

  task automatic test_stall();
    logic        found = 1'b0;
    logic [31:0] pc0;
    logic [31:0] in0;
    apply_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (if_valid) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stall_fill_timeout: if_valid %b want 1", if_valid);
    end else begin
      pc0 = if_pc;
      in0 = if_instr;
      for (int k = 0; k < 4; k++) begin
        cyc();
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (pc_next !== pc_curr) begin failures++; $display("FAIL stall_pc_hold: got %h want %h", pc_next, pc_curr); end
        checks++; if (if_valid !== 1'b1 || if_pc !== pc0 || if_instr !== in0) begin failures++; $display("FAIL stall_buffer: v %b pc %h instr %h want 1 %h %h", if_valid, if_pc, if_instr, pc0, in0); end
      end
      cyc();
      if_ready = 1'b1;
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL stall_resume: got %b want 1", imem_req_valid); end
      checks++; if (pc_next !== pc_curr + 32'd4) begin failures++; $display("FAIL stall_resume_pc: got %h want %h", pc_next, pc_curr + 32'd4); end
    end
    cyc();
  endtask

  task automatic test_redirect();
    apply_reset();
    mem_lat = 3;
    cyc();
    // request at 0 accepted at the end of this cycle
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL redir_first_req: v %b addr %h want 1 0", imem_req_valid, imem_req_addr); end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    checks++; if (pc_next !== 32'h40) begin failures++; $display("FAIL redir_pc_next: got %h want 00000040", pc_next); end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_no_req: got %b want 0", imem_req_valid); end
    cyc();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_rsp_cycle: if_valid %b req %b want 0 0", if_valid, imem_req_valid); end
    cyc();
    mem_lat = 1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_dropped: if_valid %b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin failures++; $display("FAIL redir_next_req: v %b addr %h want 1 00000040", imem_req_valid, imem_req_addr); end
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== word_at(32'h40)) begin failures++; $display("FAIL redir_delivered: v %b pc %h instr %h want 1 00000040 %h", if_valid, if_pc, if_instr, word_at(32'h40)); end
    cyc();
  endtask

  task automatic test_trap_redirect();
    logic found = 1'b0;
    apply_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (if_valid) found = 1'b1;
      else cyc();
    end
    checks++; if (!found) begin failures++; $display("FAIL trap_fill_timeout: if_valid %b want 1", if_valid); end
    cyc();
    trap_valid     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    checks++; if (pc_next !== TRAP_VEC) begin failures++; $display("FAIL trap_pc_next: got %h want %h", pc_next, TRAP_VEC); end
    cyc();
    idle_inputs();
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL trap_flush: if_valid %b want 0", if_valid); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL trap_no_misalign: got %b want 0", misalign_err); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== TRAP_VEC) begin failures++; $display("FAIL trap_next_req: v %b addr %h want 1 %h", imem_req_valid, imem_req_addr, TRAP_VEC); end
    cyc();
  endtask

  task automatic test_misalign();
    apply_reset();
    cyc();
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    @(negedge clk);
    checks++; if (pc_next !== TRAP_VEC) begin failures++; $display("FAIL mis_pc_next: got %h want %h", pc_next, TRAP_VEC); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_early: got %b want 0", misalign_err); end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_pulse: got %b want 1", misalign_err); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mis_flush: if_valid %b want 0", if_valid); end
    cyc();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_one_cycle: got %b want 0", misalign_err); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== TRAP_VEC) begin failures++; $display("FAIL mis_next_req: v %b addr %h want 1 %h", imem_req_valid, imem_req_addr, TRAP_VEC); end
    cyc();
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    idle_inputs();
    mem_lat = 3;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: v %b addr %h want 1 fffffffc", imem_req_valid, imem_req_addr); end
    checks++; if (pc_next !== 32'h0) begin failures++; $display("FAIL wrap_pc_next: got %h want 00000000", pc_next); end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pc_next !== RESET_ADDR || imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_outputs: pc_next %h req %b want %h 0", pc_next, imem_req_valid, RESET_ADDR); end
    cyc();
    inj_rsp = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL midrst_buffer: if_valid %b want 0", if_valid); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL postrst_first: if_valid %b req %b want 0 0", if_valid, imem_req_valid); end
    cyc();
    inj_rsp = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL late_rsp_ignored: if_valid %b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_ADDR) begin failures++; $display("FAIL postrst_req: v %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RESET_ADDR); end
    cyc();
    mem_lat = 1;
  endtask

  task automatic test_random();
    int unsigned r;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(1, 3);
      r              = $urandom_range(0, 99);
      trap_valid     = (r < 4);
      redirect_valid = (r < 2) || (r >= 4 && r < 12);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      rst            = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      checks++; if (pc_next !== exp_pc_next()) begin failures++; $display("FAIL rnd_pc_next @%0d: got %h want %h", i, pc_next, exp_pc_next()); end
      checks++; if (imem_req_valid !== m_issue()) begin failures++; $display("FAIL rnd_req_valid @%0d: got %b want %b", i, imem_req_valid, m_issue()); end
      checks++; if (if_valid !== m.bv) begin failures++; $display("FAIL rnd_if_valid @%0d: got %b want %b", i, if_valid, m.bv); end
      if (m.bv) begin
        checks++; if (if_pc !== m.bpc || if_instr !== word_at(m.bpc)) begin failures++; $display("FAIL rnd_buffer @%0d: pc %h instr %h want %h %h", i, if_pc, if_instr, m.bpc, word_at(m.bpc)); end
      end
      checks++; if (misalign_err !== m_mis) begin failures++; $display("FAIL rnd_misalign @%0d: got %b want %b", i, misalign_err, m_mis); end
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap_redirect();
    test_misalign();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
